// File: rtl/message_encoder_pkg.sv
// Shared constants, FSM encoding and coefficient mapping for the NewHope message encoder.
package message_encoder_pkg;

  localparam int unsigned Q          = 12289;
  localparam int unsigned HALF_Q     = 6144;
  localparam int unsigned N          = 512;
  localparam int unsigned N_HALF     = 256;
  localparam int unsigned MSG_WORDS  = 8;
  localparam int unsigned COEF_W     = 16;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned POLY_AW    = 9;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned MSG_AW     = 3;
  localparam int unsigned BIT_W      = 5;
  localparam int unsigned ST_W       = 3;

  localparam logic [ST_W-1:0] ENC_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ENC_REQ   = 3'd1;
  localparam logic [ST_W-1:0] ENC_LATCH = 3'd2;
  localparam logic [ST_W-1:0] ENC_WRITE = 3'd3;
  localparam logic [ST_W-1:0] ENC_DONE  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_REQ   = ENC_REQ,
    ST_LATCH = ENC_LATCH,
    ST_WRITE = ENC_WRITE,
    ST_DONE  = ENC_DONE
  } state_e;

  // A set message bit maps to floor(Q/2), a clear bit to zero.
  function automatic logic [COEF_W-1:0] bit_to_coef(input logic b);
    return b ? COEF_W'(HALF_Q) : '0;
  endfunction

endpackage

// File: rtl/message_encoder.sv
// Expands a 256-bit message from an 8x32 RAM into 512 poly coefficients,
// writing coefficient k and k+256 together on the two poly RAM ports.
module message_encoder
  import message_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic [MSG_AW-1:0] msg_addr,
  input  logic [WORD_W-1:0] msg_do,
  output logic              poly_wea,
  output logic [POLY_AW-1:0] poly_addra,
  output logic [COEF_W-1:0] poly_dia,
  output logic              poly_web,
  output logic [POLY_AW-1:0] poly_addrb,
  output logic [COEF_W-1:0] poly_dib
);

  state_e              state, state_n;
  logic [MSG_AW-1:0]   w_cnt, w_n;
  logic [BIT_W-1:0]    b_cnt, b_n;
  logic [WORD_W-2:0]   sh_reg, sh_n;
  logic [MSG_AW-1:0]   msg_addr_n;
  logic                busy_n, done_n;
  logic                wr_n, wr_bit;
  logic [IDX_W-1:0]    wr_idx;
  logic [POLY_AW-1:0]  addra_n, addrb_n;
  logic [COEF_W-1:0]   data_n;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      w_cnt      <= '0;
      b_cnt      <= '0;
      sh_reg     <= '0;
      msg_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      poly_wea   <= 1'b0;
      poly_web   <= 1'b0;
      poly_addra <= '0;
      poly_addrb <= '0;
      poly_dia   <= '0;
      poly_dib   <= '0;
    end else begin
      state      <= state_n;
      w_cnt      <= w_n;
      b_cnt      <= b_n;
      sh_reg     <= sh_n;
      msg_addr   <= msg_addr_n;
      busy       <= busy_n;
      done       <= done_n;
      poly_wea   <= wr_n;
      poly_web   <= wr_n;
      poly_addra <= addra_n;
      poly_addrb <= addrb_n;
      poly_dia   <= data_n;
      poly_dib   <= data_n;
    end
  end

  // Next state, counters and next output values.
  always_comb begin
    state_n    = state;
    w_n        = w_cnt;
    b_n        = b_cnt;
    sh_n       = sh_reg;
    msg_addr_n = msg_addr;
    busy_n     = busy;
    done_n     = 1'b0;
    wr_n       = 1'b0;
    wr_bit     = 1'b0;
    wr_idx     = '0;

    case (state)
      ST_IDLE: begin
        msg_addr_n = '0;
        if (start) begin
          state_n = ST_REQ;
          w_n     = '0;
          b_n     = '0;
          busy_n  = 1'b1;
        end
      end
      ST_REQ: state_n = ST_LATCH;
      ST_LATCH: begin
        // Bit 0 is written straight from the RAM; the rest queue in the shifter.
        sh_n    = msg_do[WORD_W-1:1];
        b_n     = '0;
        wr_n    = 1'b1;
        wr_bit  = msg_do[0];
        wr_idx  = {w_cnt, BIT_W'(0)};
        state_n = ST_WRITE;
      end
      ST_WRITE: begin
        if (b_cnt == BIT_W'(WORD_W - 1)) begin
          if (w_cnt == MSG_AW'(MSG_WORDS - 1)) begin
            state_n    = ST_DONE;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            msg_addr_n = '0;
          end else begin
            w_n        = w_cnt + MSG_AW'(1);
            msg_addr_n = w_cnt + MSG_AW'(1);
            state_n    = ST_REQ;
          end
        end else begin
          b_n    = b_cnt + BIT_W'(1);
          wr_n   = 1'b1;
          wr_bit = sh_reg[0];
          wr_idx = {w_cnt, b_n};
          sh_n   = {1'b0, sh_reg[WORD_W-2:1]};
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    addra_n = wr_n ? {1'b0, wr_idx} : '0;
    addrb_n = wr_n ? {1'b1, wr_idx} : '0;
    data_n  = wr_n ? bit_to_coef(wr_bit) : '0;
  end

endmodule

// File: tb/tb_message_encoder.sv
// Scoreboard bench for message_encoder: message/poly RAM models, expected
// write queue drained by an independent monitor.
module tb_message_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        done, busy;
  logic [2:0]  msg_addr;
  logic [31:0] msg_do;
  logic        poly_wea, poly_web;
  logic [8:0]  poly_addra, poly_addrb;
  logic [15:0] poly_dia, poly_dib;

  message_encoder dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .msg_addr(msg_addr), .msg_do(msg_do),
    .poly_wea(poly_wea), .poly_addra(poly_addra), .poly_dia(poly_dia),
    .poly_web(poly_web), .poly_addrb(poly_addrb), .poly_dib(poly_dib)
  );

  always #5 clk = ~clk;

  logic [31:0] msg_mem [8];
  logic [15:0] poly_mem [512];
  logic        clr = 1'b0;

  always @(posedge clk) msg_do <= msg_mem[msg_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 512; k++) poly_mem[k] <= '0;
    end else begin
      if (poly_wea) poly_mem[poly_addra] <= poly_dia;
      if (poly_web) poly_mem[poly_addrb] <= poly_dib;
    end
  end

  typedef struct {
    int          k;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  c0 = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_writes = 0;
  int  n_done = 0;
  int  last_k = 0;

  logic [56:0] outs;
  assign outs = {done, busy, msg_addr, poly_wea, poly_web, poly_addra, poly_addrb, poly_dia, poly_dib};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the expected write/done whenever the DUT presents one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst && (poly_wea || poly_web)) begin
        n_writes++;
        last_k = cyc - c0;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_edge", 64'(cyc - c0), 64'(e.k));
          check("wr_addra", poly_addra, e.a);
          check("wr_addrb", poly_addrb, e.b);
          check("wr_dia", poly_dia, e.d);
          check("wr_dib", poly_dib, e.d);
          check("wr_en_pair", {poly_wea, poly_web}, 2'b11);
        end
      end
      if (rst && done) begin
        n_done++;
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_edge", 64'(cyc - c0), 64'(done_q.pop_front()));
      end
    end
  end

  function automatic logic msg_bit(input int m);
    logic [31:0] w;
    w = msg_mem[m / 32];
    return w[m % 32];
  endfunction

  task automatic clear_poly();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic load_msg(input logic [31:0] fill, input int idx, input logic [31:0] val);
    for (int i = 0; i < 8; i++) msg_mem[i] = fill;
    if (idx >= 0) msg_mem[idx] = val;
  endtask

  task automatic check_ram();
    for (int k = 0; k < 512; k++)
      check("ram_coef", poly_mem[k], msg_bit(k % 256) ? 16'd6144 : 16'd0);
  endtask

  // Issue start, push the expected responses, and follow the run to completion.
  task automatic run(input bit extra, input int abort_at);
    int k;
    int wr0;
    int dn0;
    bit got;
    for (int m = 0; m < 256; m++)
      exp_q.push_back('{k: 34 * (m / 32) + 2 + (m % 32), a: 9'(m), b: 9'(m + 256),
                        d: msg_bit(m) ? 16'd6144 : 16'd0});
    done_q.push_back(272);
    wr0 = n_writes;
    dn0 = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b0;
    check("busy_on_accept", busy, 1);
    got = 1'b0;
    for (int i = 1; i <= 400 && !got; i++) begin
      @(posedge clk); #1;
      k = cyc - c0;
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b0;
        #1;
        check("outs_at_reset", outs, 0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("outs_in_reset", outs, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("no_done_after_abort", 64'(n_done - dn0), 0);
        return;
      end
      if (extra && k == 99) start = 1'b1;
      else if (extra && k == 100) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check("done_latency", 64'(k + 1), 273);
        check("busy_at_done", busy, 0);
      end
    end
    if (!got) check("done_timeout", 0, 1);
    if (extra) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    check("write_count", 64'(n_writes - wr0), 256);
    check("done_count", 64'(n_done - dn0), 1);
    check("queue_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    load_msg(32'h0, -1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", outs, 0);

    // All-zero message
    clear_poly();
    load_msg(32'h0, -1, 32'h0);
    run(1'b0, 0);
    check_ram();

    // All-ones message
    clear_poly();
    load_msg(32'hFFFF_FFFF, -1, 32'h0);
    run(1'b0, 0);
    check_ram();
    check("ones_coef0", poly_mem[0], 16'd6144);
    check("ones_coef511", poly_mem[511], 16'd6144);

    // Single LSB of word 0
    clear_poly();
    load_msg(32'h0, 0, 32'h0000_0001);
    run(1'b0, 0);
    check_ram();
    check("lsb_coef0", poly_mem[0], 16'd6144);
    check("lsb_coef256", poly_mem[256], 16'd6144);
    check("lsb_coef1", poly_mem[1], 16'd0);

    // MSB of word 7: final write lands after E271
    clear_poly();
    load_msg(32'h0, 7, 32'h8000_0000);
    run(1'b0, 0);
    check_ram();
    check("msb_coef255", poly_mem[255], 16'd6144);
    check("msb_coef511", poly_mem[511], 16'd6144);
    check("msb_coef254", poly_mem[254], 16'd0);
    check("last_write_edge", 64'(last_k), 271);

    // Restarts while busy and on the done cycle are ignored
    clear_poly();
    load_msg(32'h0, 2, 32'h1234_5678);
    run(1'b1, 0);
    check_ram();

    // Reset mid-run, then a clean run with word 3 = 0xA5A5A5A5
    clear_poly();
    load_msg(32'h0, 3, 32'hA5A5_A5A5);
    run(1'b0, 150);
    clear_poly();
    run(1'b0, 0);
    check_ram();
    check("a5_coef96", poly_mem[96], 16'd6144);
    check("a5_coef97", poly_mem[97], 16'd0);
    check("a5_coef98", poly_mem[98], 16'd6144);
    check("a5_coef99", poly_mem[99], 16'd0);
    check("a5_coef101", poly_mem[101], 16'd6144);
    check("a5_coef103", poly_mem[103], 16'd6144);
    check("a5_coef359", poly_mem[359], 16'd6144);
    check("a5_coef127", poly_mem[127], 16'd6144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
